// File: rtl/ex_div_pkg.sv
// Shared EX-stage definitions for the iterative divider.
// Holds the divider state encoding, handshake constants, and the opcodes it serves.
package ex_div_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIVZERO = 2'd1,
    BUSY    = 2'd2,
    DONE    = 2'd3
  } div_state_t;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  localparam int DoubleRegBusMsb = 63;
  typedef logic [DoubleRegBusMsb:0] double_reg_t;

  // Lets the decoder route an ALU opcode to the divider instead of ex_alu.
  function automatic logic is_div_op(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift left, trial-subtract the divisor,
// keep the difference and emit a 1 quotient bit when it does not underflow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0]  work,
  input  logic [WIDTH-1:0]  divisor,
  output logic [2*WIDTH:0]  next_work,
  output logic              q_bit
);

  logic [2*WIDTH:0] shifted;
  logic [WIDTH:0]   upper;
  logic [WIDTH:0]   diff;

  // NOTE: every output is assigned on every path, so no latch can be inferred.
  always_comb begin
    shifted   = work << 1;
    upper     = shifted[2*WIDTH:WIDTH];
    diff      = upper - {1'b0, divisor};
    q_bit     = (upper >= {1'b0, divisor});
    next_work = q_bit ? {diff, shifted[WIDTH-1:1], 1'b1} : shifted;
  end

endmodule

// File: rtl/ex_div.sv
// Iterative 32-cycle restoring divider for DIV/DIVU; stalls the pipeline while
// busy and returns {remainder, quotient} for the HI/LO write path.
module ex_div
  import ex_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic                 annul_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 stall_o
);

  localparam int CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [CntW-1:0]  cnt_q;
  logic [2*WIDTH:0] work_q, work_next;
  logic [WIDTH-1:0] divisor_q;
  logic             quot_neg_q, rem_neg_q;
  logic             q_bit;
  logic             accept;
  logic [WIDTH-1:0] quot_raw, rem_raw, quot_fix, rem_fix;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .work      (work_q),
    .divisor   (divisor_q),
    .next_work (work_next),
    .q_bit     (q_bit)
  );

  assign accept = (start_i == DivStart) && !annul_i;

  // Final iteration's quotient/remainder, sign-corrected for DIV.
  assign quot_raw = {work_next[WIDTH-1:1], q_bit};
  assign rem_raw  = work_next[2*WIDTH-1:WIDTH];
  assign quot_fix = quot_neg_q ? -quot_raw : quot_raw;
  assign rem_fix  = rem_neg_q  ? -rem_raw  : rem_raw;

  // Reset gating keeps the stall request quiet even if EX holds start_i during reset.
  assign stall_o = rst && start_i && !ready_o && !annul_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = (opdata2_i == '0) ? DIVZERO : BUSY;
      DIVZERO: state_d = annul_i ? IDLE : DONE;
      BUSY: begin
        if (annul_i)               state_d = IDLE;
        else if (cnt_q == LastCnt) state_d = DONE;
      end
      DONE:    if (annul_i || start_i == DivStop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      work_q     <= '0;
      divisor_q  <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      result_o   <= '0;
      ready_o    <= DivResultNotReady;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            work_q     <= {{(WIDTH+1){1'b0}}, magnitude(opdata1_i, signed_i)};
            divisor_q  <= magnitude(opdata2_i, signed_i);
            quot_neg_q <= signed_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            rem_neg_q  <= signed_i && opdata1_i[WIDTH-1];
            cnt_q      <= '0;
          end
        end
        DIVZERO: begin
          if (!annul_i) begin
            result_o <= '0;
            ready_o  <= DivResultReady;
          end
        end
        BUSY: begin
          if (!annul_i) begin
            work_q <= work_next;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
              result_o <= {rem_fix, quot_fix};
              ready_o  <= DivResultReady;
            end
          end
        end
        DONE: begin
          if (annul_i || start_i == DivStop) begin
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
